ysyx_22050854_trap_ctrl: RTL and testbench

Trap sequencer and CSR-port arbiter for the machine-mode CSR file. It owns the CSR file's two write ports and its read port. It shares them between execute-stage CSR instructions and multi-cycle trap sequences: ecall entry, timer-interrupt entry and mret return. It produces the PC redirect that the fetch stage consumes.

---
 rtl/ysyx_22050854_trap_ctrl_pkg.sv | 49 ++++
 rtl/ysyx_22050854_holdoff_cnt.sv | 37 +++
 rtl/ysyx_22050854_trap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ysyx_22050854_trap_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050854_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// trap causes, mstatus field positions, sequencer states and mstatus rewrites.
package ysyx_22050854_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] CAUSE_MTIMER  = 64'h8000_0000_0000_0007;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    IDLE,
    T_RDST,
    T_SAVE,
    T_WRST,
    MR_RDST,
    MR_WRST,
    REDIR
  } state_e;

  // Trap entry stacks MIE into MPIE and disables interrupts; only M-mode exists.
  function automatic logic [63:0] mstatus_on_trap(input logic [63:0] ms);
    logic [63:0] r;
    r                                = ms;
    r[MSTATUS_MPIE]                  = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]                   = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [63:0] mstatus_on_mret(input logic [63:0] ms);
    logic [63:0] r;
    r                                = ms;
    r[MSTATUS_MIE]                   = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE]                  = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22050854_holdoff_cnt.sv
// Saturating down-counter that masks timer interrupts for a few cycles after
// an mstatus write, while the CSR file's interrupt flag catches up.
module ysyx_22050854_holdoff_cnt #(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int unsigned CW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLDOFF);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ysyx_22050854_trap_ctrl.sv
// Trap sequencer and CSR-port arbiter: shares the CSR file's read port and two
// write ports between CSR instructions and ecall / timer-interrupt / mret sequences.
module ysyx_22050854_trap_ctrl
  import ysyx_22050854_trap_ctrl_pkg::*;
#(
  parameter int unsigned HOLDOFF     = 2,
  parameter int unsigned MTVEC_ALIGN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inst_pc,
  input  logic        ecall,
  input  logic        mret,
  input  logic        irq_ok,
  input  logic        timer_interrupt,
  input  logic        csr_req,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [63:0] csr_wdata,
  output logic        csr_ack,
  output logic [63:0] csr_rdata,
  output logic        ren,
  output logic [11:0] raddr,
  input  logic [63:0] rdata,
  output logic        wen,
  output logic [11:0] waddr1,
  output logic [63:0] wdata1,
  output logic        wen2,
  output logic [11:0] waddr2,
  output logic [63:0] wdata2,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy
);

  localparam logic [63:0] ALIGN_MASK = ~((64'd1 << MTVEC_ALIGN) - 64'd1);

  state_e      state_q, state_d;
  logic [63:0] epc_q, epc_d;
  logic [63:0] cause_q, cause_d;
  logic [63:0] mstatus_q, mstatus_d;
  logic [63:0] target_q, target_d;
  logic        hold_load;
  logic        hold_zero;
  logic        take_irq;

  ysyx_22050854_holdoff_cnt #(
    .HOLDOFF (HOLDOFF)
  ) u_holdoff (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .zero (hold_zero)
  );

  assign take_irq = irq_ok & timer_interrupt & hold_zero;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
    state_d        = state_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    mstatus_d      = mstatus_q;
    target_d       = target_q;
    hold_load      = 1'b0;
    csr_ack        = 1'b0;
    csr_rdata      = '0;
    ren            = 1'b0;
    raddr          = '0;
    wen            = 1'b0;
    waddr1         = '0;
    wdata1         = '0;
    wen2           = 1'b0;
    waddr2         = '0;
    wdata2         = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b0;

    // While rst is high every output stays quiet, so an interrupted sequence commits nothing more.
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (take_irq) begin
            epc_d   = inst_pc;
            cause_d = CAUSE_MTIMER;
            state_d = T_RDST;
          end else if (ecall) begin
            epc_d   = inst_pc;
            cause_d = CAUSE_ECALL_M;
            state_d = T_RDST;
          end else if (mret) begin
            state_d = MR_RDST;
          end else if (csr_req) begin
            ren       = 1'b1;
            raddr     = csr_addr;
            csr_ack   = 1'b1;
            csr_rdata = rdata;
            if (csr_we) begin
              wen       = 1'b1;
              waddr1    = csr_addr;
              wdata1    = csr_wdata;
              hold_load = (csr_addr == CSR_MSTATUS);
            end
          end
        end
        T_RDST: begin
          ren       = 1'b1;
          raddr     = CSR_MSTATUS;
          mstatus_d = rdata;
          state_d   = T_SAVE;
        end
        T_SAVE: begin
          wen     = 1'b1;
          waddr1  = CSR_MEPC;
          wdata1  = epc_q;
          wen2    = 1'b1;
          waddr2  = CSR_MCAUSE;
          wdata2  = cause_q;
          state_d = T_WRST;
        end
        T_WRST: begin
          wen       = 1'b1;
          waddr1    = CSR_MSTATUS;
          wdata1    = mstatus_on_trap(mstatus_q);
          ren       = 1'b1;
          raddr     = CSR_MTVEC;
          target_d  = rdata;
          hold_load = 1'b1;
          state_d   = REDIR;
        end
        MR_RDST: begin
          ren       = 1'b1;
          raddr     = CSR_MSTATUS;
          mstatus_d = rdata;
          state_d   = MR_WRST;
        end
        MR_WRST: begin
          wen       = 1'b1;
          waddr1    = CSR_MSTATUS;
          wdata1    = mstatus_on_mret(mstatus_q);
          ren       = 1'b1;
          raddr     = CSR_MEPC;
          target_d  = rdata;
          hold_load = 1'b1;
          state_d   = REDIR;
        end
        REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = target_q & ALIGN_MASK;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are only consumed in states that follow their load.
  always_ff @(posedge clk) begin
    epc_q     <= epc_d;
    cause_q   <= cause_d;
    mstatus_q <= mstatus_d;
    target_q  <= target_d;
  end

endmodule

// File: tb/tb_ysyx_22050854_trap_ctrl.sv
// Directed plus randomized bench for the trap sequencer, with a behavioural CSR
// file on the ports and a reference model of CSR contents and sequence timing.
module tb_ysyx_22050854_trap_ctrl;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] inst_pc;
  logic        ecall, mret, irq_ok, timer_interrupt;
  logic        csr_req, csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic        csr_ack;
  logic [63:0] csr_rdata;
  logic        ren;
  logic [11:0] raddr;
  logic [63:0] rdata;
  logic        wen, wen2;
  logic [11:0] waddr1, waddr2;
  logic [63:0] wdata1, wdata2;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22050854_trap_ctrl #(
    .HOLDOFF     (2),
    .MTVEC_ALIGN (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_pc         (inst_pc),
    .ecall           (ecall),
    .mret            (mret),
    .irq_ok          (irq_ok),
    .timer_interrupt (timer_interrupt),
    .csr_req         (csr_req),
    .csr_addr        (csr_addr),
    .csr_we          (csr_we),
    .csr_wdata       (csr_wdata),
    .csr_ack         (csr_ack),
    .csr_rdata       (csr_rdata),
    .ren             (ren),
    .raddr           (raddr),
    .rdata           (rdata),
    .wen             (wen),
    .waddr1          (waddr1),
    .wdata1          (wdata1),
    .wen2            (wen2),
    .waddr2          (waddr2),
    .wdata2          (wdata2),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .busy            (busy)
  );

  // Behavioural CSR file: combinational read, writes land at the next posedge.
  logic [63:0] csr_mem [4096];
  assign rdata = csr_mem[raddr];
  always @(posedge clk) begin
    if (wen)  csr_mem[waddr1] <= wdata1;
    if (wen2) csr_mem[waddr2] <= wdata2;
  end

  // Reference model: what each CSR should hold according to the architectural rules.
  logic [63:0] ref_csr [logic [11:0]];

  function automatic logic [63:0] exp_trap_ms(input logic [63:0] m);
    logic [63:0] mie;
    mie = (m >> 3) & 64'd1;
    return (m & ~64'h1888) | (mie << 7) | 64'h1800;
  endfunction

  function automatic logic [63:0] exp_mret_ms(input logic [63:0] m);
    logic [63:0] mpie;
    mpie = (m >> 7) & 64'd1;
    return (m & ~64'h1888) | (mpie << 3) | 64'h80 | 64'h1800;
  endfunction

  function automatic logic [63:0] aligned4(input logic [63:0] a);
    return a - (a % 64'd4);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic csr_op(input logic [11:0] a, input logic we, input logic [63:0] wd);
    csr_req   = 1'b1;
    csr_addr  = a;
    csr_we    = we;
    csr_wdata = wd;
    #1;
    check("csr_ack", csr_ack, 1);
    check("csr_ren", ren, 1);
    check("csr_raddr", raddr, a);
    if (ref_csr.exists(a)) check("csr_rdata_old", csr_rdata, ref_csr[a]);
    check("csr_wen", wen, we);
    check("csr_wen2", wen2, 0);
    check("csr_busy", busy, 0);
    if (we) begin
      check("csr_waddr1", waddr1, a);
      check("csr_wdata1", wdata1, wd);
    end
    tick();
    csr_req = 1'b0;
    csr_we  = 1'b0;
    if (we) begin
      ref_csr[a] = wd;
      check("csr_landed", csr_mem[a], wd);
    end
  endtask

  // Trap entry: event cycle N, busy N+1..N+4, redirect at N+4, IDLE at N+5.
  task automatic run_trap(input bit irq, input logic [63:0] pc, input bit keep_irq);
    logic [63:0] exp_ms, exp_cause, exp_tgt;
    exp_ms    = exp_trap_ms(ref_csr[A_MSTATUS]);
    exp_cause = irq ? 64'h8000_0000_0000_0007 : 64'd11;
    exp_tgt   = aligned4(ref_csr[A_MTVEC]);
    inst_pc   = pc;
    if (irq) begin
      timer_interrupt = 1'b1;
      irq_ok          = 1'b1;
    end else begin
      ecall = 1'b1;
    end
    #1;
    check("trap_ev_busy", busy, 0);
    check("trap_ev_ack", csr_ack, 0);
    check("trap_ev_wen", wen, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        inst_pc = rand64();
        ecall   = 1'b0;
        if (!keep_irq) begin
          timer_interrupt = 1'b0;
          irq_ok          = 1'b0;
        end
      end
      if (k == 5) begin
        csr_req = 1'b0;
        csr_we  = 1'b0;
      end
      #1;
      check("trap_busy", busy, (k <= 4));
      check("trap_redir_v", redirect_valid, (k == 4));
      if (k <= 4) check("trap_ack", csr_ack, 0);
      if (k == 1) begin
        check("t_rdst_ren", ren, 1);
        check("t_rdst_raddr", raddr, A_MSTATUS);
        check("t_rdst_wen", wen, 0);
      end
      if (k == 2) begin
        check("t_save_wen", wen, 1);
        check("t_save_waddr1", waddr1, A_MEPC);
        check("t_save_epc", wdata1, pc);
        check("t_save_wen2", wen2, 1);
        check("t_save_waddr2", waddr2, A_MCAUSE);
        check("t_save_cause", wdata2, exp_cause);
        check("t_save_ren", ren, 0);
      end
      if (k == 3) begin
        check("t_wrst_wen", wen, 1);
        check("t_wrst_waddr1", waddr1, A_MSTATUS);
        check("t_wrst_mstatus", wdata1, exp_ms);
        check("t_wrst_wen2", wen2, 0);
        check("t_wrst_ren", ren, 1);
        check("t_wrst_raddr", raddr, A_MTVEC);
      end
      if (k == 4) check("trap_redir_pc", redirect_pc, exp_tgt);
      else        check("trap_pc_quiet", redirect_pc, 0);
    end
    ref_csr[A_MEPC]    = pc;
    ref_csr[A_MCAUSE]  = exp_cause;
    ref_csr[A_MSTATUS] = exp_ms;
    check("trap_mepc", csr_mem[A_MEPC], ref_csr[A_MEPC]);
    check("trap_mcause", csr_mem[A_MCAUSE], ref_csr[A_MCAUSE]);
    check("trap_mstatus", csr_mem[A_MSTATUS], ref_csr[A_MSTATUS]);
  endtask

  // mret: event cycle N, busy N+1..N+3, redirect at N+3.
  task automatic run_mret();
    logic [63:0] exp_ms, exp_tgt;
    exp_ms  = exp_mret_ms(ref_csr[A_MSTATUS]);
    exp_tgt = aligned4(ref_csr[A_MEPC]);
    mret    = 1'b1;
    #1;
    check("mret_ev_busy", busy, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) mret = 1'b0;
      #1;
      check("mret_busy", busy, (k <= 3));
      check("mret_redir_v", redirect_valid, (k == 3));
      if (k == 1) begin
        check("mr_rdst_ren", ren, 1);
        check("mr_rdst_raddr", raddr, A_MSTATUS);
      end
      if (k == 2) begin
        check("mr_wrst_wen", wen, 1);
        check("mr_wrst_waddr1", waddr1, A_MSTATUS);
        check("mr_wrst_mstatus", wdata1, exp_ms);
        check("mr_wrst_wen2", wen2, 0);
        check("mr_wrst_raddr", raddr, A_MEPC);
      end
      if (k == 3) check("mret_redir_pc", redirect_pc, exp_tgt);
    end
    ref_csr[A_MSTATUS] = exp_ms;
    check("mret_mstatus", csr_mem[A_MSTATUS], ref_csr[A_MSTATUS]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; inst_pc = '0; ecall = 1'b0; mret = 1'b0; irq_ok = 1'b0;
    timer_interrupt = 1'b0; csr_req = 1'b1; csr_addr = A_MTVEC; csr_we = 1'b1;
    csr_wdata = 64'h1234;

    // Reset: every output quiet even with a request pending.
    idle(2);
    check("rst_ack", csr_ack, 0);
    check("rst_ren", ren, 0);
    check("rst_wen", wen, 0);
    check("rst_wen2", wen2, 0);
    check("rst_redir_v", redirect_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_redir_pc", redirect_pc, 0);
    check("rst_rdata", csr_rdata, 0);
    rst = 1'b0; csr_req = 1'b0; csr_we = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);

    // Seed the CSR file through the instruction port.
    csr_op(A_MSTATUS, 1'b1, 64'h8);
    csr_op(A_MTVEC,   1'b1, rand64());
    csr_op(A_MEPC,    1'b1, rand64());
    csr_op(A_MCAUSE,  1'b1, rand64());
    csr_op(A_MIE,     1'b1, rand64());
    csr_op(A_MIP,     1'b1, rand64());

    // CSR write returns the old value, then reads back.
    csr_op(A_MTVEC, 1'b1, 64'h8000_0100);
    csr_op(A_MTVEC, 1'b0, 64'h0);

    // ecall with mtvec 0x8000_0103 and mstatus 0x8.
    csr_op(A_MTVEC, 1'b1, 64'h8000_0103);
    run_trap(1'b0, 64'h8000_0040, 1'b0);
    check("ecall_mstatus_const", csr_mem[A_MSTATUS], 64'h1880);
    check("ecall_mepc_const", csr_mem[A_MEPC], 64'h8000_0040);
    check("ecall_mcause_const", csr_mem[A_MCAUSE], 64'd11);

    // mret with mepc 0x8000_0044 and mstatus 0x1880.
    csr_op(A_MEPC, 1'b1, 64'h8000_0044);
    run_mret();
    check("mret_mstatus_const", csr_mem[A_MSTATUS], 64'h1888);

    // Interrupt, ecall and csr_req together: interrupt wins, no ack while busy.
    idle(2);
    ecall = 1'b1; csr_req = 1'b1; csr_addr = A_MIE; csr_we = 1'b1; csr_wdata = rand64();
    run_trap(1'b1, 64'h8000_0200, 1'b0);
    check("irq_mcause_const", csr_mem[A_MCAUSE], 64'h8000_0000_0000_0007);
    run_mret();
    run_trap(1'b0, 64'h8000_0200, 1'b0);
    run_mret();

    // Interrupt held high through entry: masked for the holdoff window, then retaken.
    idle(2);
    run_trap(1'b1, rand64(), 1'b1);
    tick();
    check("holdoff_trap_block", busy, 0);
    run_trap(1'b1, rand64(), 1'b0);
    run_mret();

    // A CSR-instruction write to mstatus also reloads the holdoff.
    idle(2);
    csr_op(A_MSTATUS, 1'b1, rand64());
    timer_interrupt = 1'b1; irq_ok = 1'b1;
    tick();
    check("holdoff_csr_block1", busy, 0);
    tick();
    check("holdoff_csr_block2", busy, 0);
    run_trap(1'b1, rand64(), 1'b0);
    run_mret();

    // Reset during T_SAVE: back to IDLE, no redirect, mepc/mcause untouched.
    ecall = 1'b1; inst_pc = rand64();
    tick();
    ecall = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_wen", wen, 0);
    check("midrst_wen2", wen2, 0);
    check("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_idle_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_redir", redirect_valid, 0);
      tick();
    end
    check("midrst_mepc_kept", csr_mem[A_MEPC], ref_csr[A_MEPC]);
    check("midrst_mcause_kept", csr_mem[A_MCAUSE], ref_csr[A_MCAUSE]);

    // Randomized traffic against the model.
    for (int it = 0; it < 10; it++) begin
      logic [11:0] addrs [6];
      addrs = '{A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE, A_MIP};
      csr_op(A_MTVEC, 1'b1, rand64());
      csr_op(A_MSTATUS, 1'b1, rand64());
      csr_op(addrs[$urandom_range(5)], 1'b0, 64'h0);
      if ($urandom_range(1) == 1) csr_op(A_MEPC, 1'b1, rand64());
      idle(2);
      run_trap($urandom_range(1) == 1, rand64(), 1'b0);
      csr_op(addrs[$urandom_range(5)], 1'b0, 64'h0);
      run_mret();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
